// File: rtl/conv_window_scheduler.sv
// Frame sequencer for the padded-image buffer: gates NPIX pixels in, then issues every window origin in raster order.
// Optional build macro WIN_STALL_CNT_EN adds a saturating count of backpressured SCAN cycles (stall_cnt).
module conv_window_scheduler #(
    parameter int IMG_SIZE    = 5,
    parameter int FILTER_SIZE = 3
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          pad_mode_in,
    input  logic                                          pixel_valid,
    output logic                                          in_ready,
    output logic                                          buf_wr_en,
    output logic                                          buf_pad_mode,
    output logic                                          win_valid,
    input  logic                                          win_ready,
    output logic [$clog2(IMG_SIZE+2*((FILTER_SIZE-1)/2))-1:0] win_row,
    output logic [$clog2(IMG_SIZE+2*((FILTER_SIZE-1)/2))-1:0] win_col,
    output logic                                          win_last,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err_overrun
`ifdef WIN_STALL_CNT_EN
    ,output logic [15:0]                                  stall_cnt
`endif
);

    localparam int PADDING     = (FILTER_SIZE - 1) / 2;
    localparam int PADDED_SIZE = IMG_SIZE + 2 * PADDING;
    localparam int CW          = $clog2(PADDED_SIZE);
    localparam int NPIX        = IMG_SIZE * IMG_SIZE;
    localparam int PW          = $clog2(NPIX + 1);

    localparam logic [CW-1:0] LAST_RC  = CW'(IMG_SIZE - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        SCAN   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          pad_mode_q, pad_mode_d;
    logic          err_q, err_d;
    logic          start_acc;
    logic          at_last_win;

    assign start_acc   = (state_q == IDLE) && start;
    assign at_last_win = (row_q == LAST_RC) && (col_q == LAST_RC);

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        pad_mode_d = pad_mode_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    pad_mode_d = pad_mode_in;
                    pix_cnt_d  = '0;
                    row_d      = '0;
                    col_d      = '0;
                    err_d      = 1'b0;
                end
            end
            LOAD: begin
                if (pixel_valid) begin
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d   = SETTLE;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + PW'(1);
                    end
                end
            end
            SETTLE: state_d = SCAN;
            SCAN: begin
                if (win_ready) begin
                    if (at_last_win) begin
                        state_d = DONE;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == LAST_RC) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A stray pixel always flags, even in the cycle a start is accepted.
        if (pixel_valid && (state_q != LOAD)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            pad_mode_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            pad_mode_q <= pad_mode_d;
            err_q      <= err_d;
        end
    end

    assign in_ready     = (state_q == LOAD);
    assign buf_wr_en    = pixel_valid && in_ready;
    assign buf_pad_mode = pad_mode_q;
    assign win_valid    = (state_q == SCAN);
    assign win_row      = row_q;
    assign win_col      = col_q;
    assign win_last     = win_valid && at_last_win;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign err_overrun  = err_q;

`ifdef WIN_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if (win_valid && !win_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule
